video_ram_scroll: RTL

Parametrised successor to the CPU/VGA video RAM. It stores the frame buffer as `LANES` byte-lane banks, which gives the CPU port per-lane write enables and gives the VGA port a byte-wide read. Compared with the current block it adds a hardware scroll offset on the VGA port, correctly pipelined lane selection, and a fill engine that clears or fills the whole buffer while stalling the CPU. It sits between the data-memory bus decoder and the VGA controller.

---
 rtl/video_pkg.sv | 25 ++
 rtl/video_ram_bank.sv | 27 ++
 rtl/video_ram_scroll.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared defaults, fill FSM state type and lane helper for video_ram_scroll
package video_pkg;

    localparam int LANES_DEF  = 4;
    localparam int LANE_W_DEF = 8;
    localparam int DEPTH_DEF  = 1024;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    // log2 of a power-of-two lane count; number of byte-select bits in an address
    function automatic int lane_bits(input int lanes);
        int b;
        b = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << b) < lanes) begin
                b = b + 1;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/video_ram_bank.sv
// rtl/video_ram_bank.sv - one byte-lane bank: simple dual-port synchronous RAM with registered reads
module video_ram_bank #(
    parameter int DEPTH  = 1024,
    parameter int LANE_W = 8,
    parameter int WORD_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_a,
    input  logic [WORD_W-1:0] addr_a,
    input  logic [LANE_W-1:0] din_a,
    output logic [LANE_W-1:0] q_a,
    input  logic [WORD_W-1:0] addr_b,
    output logic [LANE_W-1:0] q_b
);

    logic [LANE_W-1:0] mem [DEPTH];

    // Port A writes and reads old data; port B is read-only, so a same-edge write is not seen
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= din_a;
        end
        q_a <= mem[addr_a];
        q_b <= mem[addr_b];
    end

endmodule

// File: rtl/video_ram_scroll.sv
// rtl/video_ram_scroll.sv - lane-banked CPU/VGA frame buffer with scroll offset and fill engine
module video_ram_scroll
    import video_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int LANE_W = LANE_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH * LANES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [LANES-1:0]          sel,
    input  logic [LANES*LANE_W-1:0]   data_i,
    output logic [LANES*LANE_W-1:0]   data_o,
    output logic                      ready,
    input  logic                      fill_start,
    input  logic [LANE_W-1:0]         fill_value,
    output logic                      fill_busy,
    input  logic [ADDR_W-1:0]         scroll,
    input  logic [ADDR_W-1:0]         vga_rdaddress,
    output logic [LANE_W-1:0]         vga_q
);

    localparam int LB     = lane_bits(LANES);
    localparam int WORD_W = ADDR_W - LB;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(DEPTH - 1);

    fill_state_t state, state_n;
    logic [WORD_W-1:0]       counter, counter_n;
    logic [LANE_W-1:0]       fill_byte, fill_byte_n;

    logic                    accept;
    logic [WORD_W-1:0]       wr_addr;
    logic [LANES-1:0]        wr_en;
    logic [LANES*LANE_W-1:0] wr_data;
    logic [LANES*LANE_W-1:0] cpu_word;
    logic [LANES*LANE_W-1:0] vga_word;
    logic [ADDR_W-1:0]       ea;
    logic [LB-1:0]           lane_d;
    logic                    rd_v;
    logic [LANES*LANE_W-1:0] cpu_s1;
    logic [LANE_W-1:0]       vga_s1;
    logic                    unused_addr_bits;

    assign ready     = !rst && (state == IDLE);
    assign accept    = ce && ready;
    assign fill_busy = (state == FILL);
    assign ea        = vga_rdaddress + scroll;
    assign unused_addr_bits = ^addr[LB-1:0];

    // Write port mux: the fill engine owns every lane while running, otherwise the CPU writes by sel
    always_comb begin
        wr_addr = addr[ADDR_W-1:LB];
        wr_en   = '0;
        wr_data = data_i;
        if (state == FILL && !rst) begin
            wr_addr = counter;
            wr_en   = '1;
            wr_data = {LANES{fill_byte}};
        end else if (accept && we) begin
            wr_en = sel;
        end
    end

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_bank
            video_ram_bank #(
                .DEPTH  (DEPTH),
                .LANE_W (LANE_W),
                .WORD_W (WORD_W)
            ) u_bank (
                .clk    (clk),
                .we_a   (wr_en[k]),
                .addr_a (wr_addr),
                .din_a  (wr_data[k*LANE_W +: LANE_W]),
                .q_a    (cpu_word[k*LANE_W +: LANE_W]),
                .addr_b (ea[ADDR_W-1:LB]),
                .q_b    (vga_word[k*LANE_W +: LANE_W])
            );
        end
    endgenerate

    // Fill FSM next state: a pulse in IDLE latches the byte; FILL walks every word once
    always_comb begin
        state_n     = state;
        counter_n   = counter;
        fill_byte_n = fill_byte;
        case (state)
            IDLE: begin
                if (fill_start) begin
                    state_n     = FILL;
                    counter_n   = '0;
                    fill_byte_n = fill_value;
                end
            end
            FILL: begin
                counter_n = counter + 1'b1;
                if (counter == LAST_WORD) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Fill FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            fill_byte <= '0;
        end else begin
            state     <= state_n;
            counter   <= counter_n;
            fill_byte <= fill_byte_n;
        end
    end

    // Output pipelines: CPU read word zeroed unless a read was accepted; VGA lane picked with delayed index
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_v   <= 1'b0;
            cpu_s1 <= '0;
            data_o <= '0;
            lane_d <= '0;
            vga_s1 <= '0;
            vga_q  <= '0;
        end else begin
            rd_v   <= accept && !we;
            cpu_s1 <= rd_v ? cpu_word : '0;
            data_o <= cpu_s1;
            lane_d <= ea[LB-1:0];
            vga_s1 <= vga_word[lane_d*LANE_W +: LANE_W];
            vga_q  <= vga_s1;
        end
    end

endmodule
